// File: rtl/uart_mmio_fifo.sv
// Memory-mapped UART front end: TX/RX byte FIFOs, STATUS and BAUD registers, TX hand-off FSM.
// Optional feature: define UART_IRQ_EN to add the IRQ_EN register (BASE+8) and a registered irq output.
module uart_mmio_fifo #(
    parameter int          DEPTH     = 8,
    parameter logic [31:0] BASE_ADDR = 32'h10010000,
    parameter logic [15:0] BAUD_RST  = 16'h0003
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    input  logic        write_enable,
    input  logic        read_enable,
    output logic [31:0] read_data,
    output logic        hit,
    output logic [7:0]  tx_data,
    output logic        tx_start,
    input  logic        tx_busy,
    input  logic [7:0]  rx_byte,
    input  logic        rx_valid,
`ifdef UART_IRQ_EN
    output logic        irq,
`endif
    output logic [15:0] baud_max
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, START, ACK, DONE} txState_t;

    txState_t    state_q;
    logic [7:0]  txData_q;
    logic        txStart_q;
    logic [15:0] baud_q;
    logic        overrun_q, overrun_d;
    logic        overflow_q, overflow_d;
    logic [7:0]  txMem_q [DEPTH];
    logic [7:0]  rxMem_q [DEPTH];
    logic [AW:0] txWr_q, txRd_q, rxWr_q, rxRd_q;

    logic isData, isStatus, isBaud, statusClr;
    logic txEmpty, txFull, rxEmpty, rxFull, txActive;
    logic txPush, txPop, rxPush, rxPop;
    logic unusedWdata;

    assign unusedWdata = ^write_data[31:16];

    assign isData   = (address == BASE_ADDR);
    assign isStatus = (address == BASE_ADDR + 32'd5);
    assign isBaud   = (address == BASE_ADDR + 32'h100);

    assign txEmpty  = (txWr_q == txRd_q);
    assign txFull   = (txWr_q[AW] != txRd_q[AW]) && (txWr_q[AW-1:0] == txRd_q[AW-1:0]);
    assign rxEmpty  = (rxWr_q == rxRd_q);
    assign rxFull   = (rxWr_q[AW] != rxRd_q[AW]) && (rxWr_q[AW-1:0] == rxRd_q[AW-1:0]);
    assign txActive = !txEmpty || (state_q != IDLE);

    assign txPush    = write_enable && isData && !txFull;
    assign txPop     = (state_q == IDLE) && !txEmpty && !tx_busy;
    assign rxPop     = read_enable && isData && !rxEmpty;
    assign rxPush    = rx_valid && (!rxFull || rxPop);
    assign statusClr = read_enable && isStatus;

    // A new error event in the same cycle as the clearing read keeps the flag set.
    assign overflow_d = (write_enable && isData && txFull) || (overflow_q && !statusClr);
    assign overrun_d  = (rx_valid && rxFull && !rxPop) || (overrun_q && !statusClr);

    always_ff @(posedge clk) begin
        if (txPush) txMem_q[txWr_q[AW-1:0]] <= write_data[7:0];
        if (rxPush) rxMem_q[rxWr_q[AW-1:0]] <= rx_byte;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            txWr_q     <= '0;
            txRd_q     <= '0;
            rxWr_q     <= '0;
            rxRd_q     <= '0;
            overrun_q  <= 1'b0;
            overflow_q <= 1'b0;
            baud_q     <= BAUD_RST;
        end else begin
            if (txPush) txWr_q <= txWr_q + 1'b1;
            if (txPop)  txRd_q <= txRd_q + 1'b1;
            if (rxPush) rxWr_q <= rxWr_q + 1'b1;
            if (rxPop)  rxRd_q <= rxRd_q + 1'b1;
            if (write_enable && isBaud) baud_q <= write_data[15:0];
            overrun_q  <= overrun_d;
            overflow_q <= overflow_d;
        end
    end

    // tx_data is only loaded on leaving IDLE, so it holds through the whole Uart frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            txData_q  <= 8'h00;
            txStart_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    txStart_q <= 1'b0;
                    if (txPop) begin
                        txData_q  <= txMem_q[txRd_q[AW-1:0]];
                        txStart_q <= 1'b1;
                        state_q   <= START;
                    end
                end
                START: begin
                    txStart_q <= 1'b0;
                    state_q   <= ACK;
                end
                ACK:     if (tx_busy)  state_q <= DONE;
                DONE:    if (!tx_busy) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef UART_IRQ_EN
    logic       isIrqEn;
    logic [2:0] irqEn_q;
    logic       irq_q;

    assign isIrqEn = (address == BASE_ADDR + 32'd8);

    always_ff @(posedge clk) begin
        if (rst) begin
            irqEn_q <= 3'b000;
            irq_q   <= 1'b0;
        end else begin
            if (write_enable && isIrqEn) irqEn_q <= write_data[2:0];
            irq_q <= |(irqEn_q & {overrun_q | overflow_q, txEmpty, !rxEmpty});
        end
    end

    assign irq = irq_q;
    assign hit = isData || isStatus || isBaud || isIrqEn;
`else
    assign hit = isData || isStatus || isBaud;
`endif

    always_comb begin
        read_data = 32'h0;
        if (isData) begin
            if (!rxEmpty) read_data = {24'h0, rxMem_q[rxRd_q[AW-1:0]]};
        end else if (isStatus) begin
            read_data = {25'h0, txActive, txFull, 2'b00, overflow_q, overrun_q, !rxEmpty};
        end else if (isBaud) begin
            read_data = {16'h0, baud_q};
        end
`ifdef UART_IRQ_EN
        else if (isIrqEn) begin
            read_data = {29'h0, irqEn_q};
        end
`endif
    end

    assign tx_data  = txData_q;
    assign tx_start = txStart_q;
    assign baud_max = baud_q;
endmodule

// File: tb/tb_uart_mmio_fifo.sv
// Self-checking bench for uart_mmio_fifo: expected TX bytes go into a scoreboard queue and are
// popped when tx_start pulses; a small Uart model answers with tx_busy and optional loopback.
module tb_uart_mmio_fifo;
    localparam int          DEPTH  = 8;
    localparam logic [31:0] BASE   = 32'h10010000;
    localparam logic [31:0] STATUS = BASE + 32'd5;
    localparam logic [31:0] BAUD   = BASE + 32'h100;
    localparam int          FRAME  = 10;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] address;
    logic [31:0] write_data;
    logic        write_enable;
    logic        read_enable;
    logic [31:0] read_data;
    logic        hit;
    logic [7:0]  tx_data;
    logic        tx_start;
    logic        tx_busy;
    logic [7:0]  rx_byte;
    logic        rx_valid;
    logic [15:0] baud_max;

    int          errors = 0;
    int          checks = 0;
    logic [7:0]  txQ [$];
    logic [7:0]  monExp;
    logic [7:0]  modelByte;
    bit          autoUart = 1'b0;
    bit          loopback = 1'b0;
    logic [31:0] rd;

    uart_mmio_fifo #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .BAUD_RST(16'h0003)) dut (
        .clk(clk), .rst(rst), .address(address), .write_data(write_data),
        .write_enable(write_enable), .read_enable(read_enable), .read_data(read_data),
        .hit(hit), .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy),
        .rx_byte(rx_byte), .rx_valid(rx_valid), .baud_max(baud_max)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One bus cycle; rdata is the combinational load data seen during that cycle.
    task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] wdata,
                                 input bit we, input bit re, output logic [31:0] rdata);
        @(negedge clk);
        address      = addr;
        write_data   = wdata;
        write_enable = we;
        read_enable  = re;
        #1 rdata = read_data;
        @(posedge clk);
        #1;
        write_enable = 1'b0;
        read_enable  = 1'b0;
    endtask

    task automatic rxStim(input logic [7:0] b, input bit pop, output logic [31:0] rdata);
        @(negedge clk);
        rx_byte     = b;
        rx_valid    = 1'b1;
        address     = BASE;
        read_enable = pop;
        #1 rdata = read_data;
        @(posedge clk);
        #1;
        rx_valid    = 1'b0;
        read_enable = 1'b0;
    endtask

    task automatic waitIdle(input string tag);
        bit done = 1'b0;
        address = STATUS;
        for (int i = 0; i < 2000 && !done; i++) begin
            @(negedge clk);
            #1;
            if (txQ.size() == 0 && tx_busy === 1'b0 && read_data[6] === 1'b0) done = 1'b1;
        end
        checkOutput(tag, {31'h0, done}, 32'h1);
    endtask

    // Scoreboard side: every tx_start must match the oldest expected byte.
    always @(negedge clk) begin
        if (tx_start === 1'b1) begin
            if (txQ.size() == 0) begin
                checkOutput("unexpectedTxStart", 32'h1, 32'h0);
            end else begin
                monExp = txQ.pop_front();
                checkOutput("txData", {24'h0, tx_data}, {24'h0, monExp});
                checkOutput("txBusyAtStart", {31'h0, tx_busy}, 32'h0);
            end
        end
    end

    // Uart model: busy for FRAME cycles after each start, optional loopback into rx.
    always begin
        @(negedge clk);
        if (autoUart && tx_start === 1'b1) begin
            modelByte = tx_data;
            repeat (2) @(negedge clk);
            tx_busy = 1'b1;
            repeat (FRAME) @(negedge clk);
            checkOutput("txDataStable", {24'h0, tx_data}, {24'h0, modelByte});
            tx_busy = 1'b0;
            if (loopback) begin
                rx_byte  = modelByte;
                rx_valid = 1'b1;
                @(negedge clk);
                rx_valid = 1'b0;
            end
        end
    end

    initial begin
        rst = 1'b1; address = 32'h0; write_data = 32'h0; write_enable = 1'b0;
        read_enable = 1'b0; tx_busy = 1'b0; rx_byte = 8'h00; rx_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        applyStimulus(STATUS, 32'h0, 1'b0, 1'b0, rd);
        checkOutput("statusReset", rd, 32'h00);
        applyStimulus(BAUD, 32'h0, 1'b0, 1'b0, rd);
        checkOutput("baudReset", rd, 32'h0003);
        checkOutput("baudMaxReset", {16'h0, baud_max}, 32'h0003);
        applyStimulus(BASE, 32'h0, 1'b0, 1'b0, rd);
        checkOutput("dataEmpty", rd, 32'h0);
        checkOutput("txStartReset", {31'h0, tx_start}, 32'h0);
        checkOutput("txDataReset", {24'h0, tx_data}, 32'h0);

        // Address decode
        @(negedge clk); address = BASE + 32'd8; #1;
        checkOutput("hitIrqUndecoded", {31'h0, hit}, 32'h0);
        address = BASE + 32'd4; #1;
        checkOutput("hitGap", {31'h0, hit}, 32'h0);
        checkOutput("readGap", read_data, 32'h0);
        address = STATUS; #1;
        checkOutput("hitStatus", {31'h0, hit}, 32'h1);

        // Three back-to-back stores
        autoUart = 1'b1;
        txQ.push_back(8'h41); txQ.push_back(8'h42); txQ.push_back(8'h43);
        applyStimulus(BASE, 32'h41, 1'b1, 1'b0, rd);
        applyStimulus(BASE, 32'h42, 1'b1, 1'b0, rd);
        applyStimulus(BASE, 32'h43, 1'b1, 1'b0, rd);
        waitIdle("idleAfterThree");

        // TX overflow while the Uart stays busy
        autoUart = 1'b0;
        @(negedge clk); tx_busy = 1'b1;
        for (int i = 0; i < DEPTH; i++) txQ.push_back(8'h10 + 8'(i));
        for (int i = 0; i < DEPTH; i++) applyStimulus(BASE, 32'h10 + i, 1'b1, 1'b0, rd);
        applyStimulus(BASE, 32'h99, 1'b1, 1'b0, rd);
        applyStimulus(STATUS, 32'h0, 1'b0, 1'b1, rd);
        checkOutput("statusOverflow", rd, 32'h64);
        applyStimulus(STATUS, 32'h0, 1'b0, 1'b0, rd);
        checkOutput("statusOverflowCleared", rd, 32'h60);
        @(negedge clk); tx_busy = 1'b0; autoUart = 1'b1;
        waitIdle("idleAfterOverflow");

        // Loopback of one byte
        loopback = 1'b1;
        txQ.push_back(8'h5A);
        applyStimulus(BASE, 32'h5A, 1'b1, 1'b0, rd);
        waitIdle("idleLoopback");
        repeat (3) @(negedge clk);
        loopback = 1'b0;
        applyStimulus(STATUS, 32'h0, 1'b0, 1'b0, rd);
        checkOutput("statusRxReady", rd, 32'h01);
        applyStimulus(BASE, 32'h0, 1'b0, 1'b1, rd);
        checkOutput("loopbackData", rd, 32'h5A);
        applyStimulus(STATUS, 32'h0, 1'b0, 1'b0, rd);
        checkOutput("statusRxDrained", rd, 32'h00);

        // RX full, simultaneous push and pop, then overrun
        for (int i = 0; i < DEPTH; i++) rxStim(8'hA0 + 8'(i), 1'b0, rd);
        rxStim(8'hB0, 1'b1, rd);
        checkOutput("rxPopWhileFull", rd, 32'hA0);
        applyStimulus(STATUS, 32'h0, 1'b0, 1'b0, rd);
        checkOutput("statusNoOverrun", rd, 32'h01);
        rxStim(8'hCC, 1'b0, rd);
        applyStimulus(STATUS, 32'h0, 1'b0, 1'b0, rd);
        checkOutput("statusOverrun", rd, 32'h03);
        applyStimulus(BASE, 32'h0, 1'b0, 1'b0, rd);
        checkOutput("rxHeadUnchanged", rd, 32'hA1);
        for (int i = 1; i < DEPTH; i++) begin
            applyStimulus(BASE, 32'h0, 1'b0, 1'b1, rd);
            checkOutput("rxDrain", rd, 32'hA0 + i);
        end
        applyStimulus(BASE, 32'h0, 1'b0, 1'b1, rd);
        checkOutput("rxDrainLast", rd, 32'hB0);
        applyStimulus(STATUS, 32'h0, 1'b0, 1'b1, rd);
        checkOutput("statusOverrunOnly", rd, 32'h02);
        applyStimulus(STATUS, 32'h0, 1'b0, 1'b0, rd);
        checkOutput("statusClear", rd, 32'h00);

        // Baud register
        applyStimulus(BAUD, 32'hABCD1234, 1'b1, 1'b0, rd);
        checkOutput("baudMaxWritten", {16'h0, baud_max}, 32'h1234);
        applyStimulus(BAUD, 32'h0, 1'b0, 1'b0, rd);
        checkOutput("baudRead", rd, 32'h1234);

        // Reset while the FSM waits in ACK with three bytes queued
        autoUart = 1'b0;
        txQ.push_back(8'h71);
        applyStimulus(BASE, 32'h71, 1'b1, 1'b0, rd);
        applyStimulus(BASE, 32'h72, 1'b1, 1'b0, rd);
        applyStimulus(BASE, 32'h73, 1'b1, 1'b0, rd);
        applyStimulus(BASE, 32'h74, 1'b1, 1'b0, rd);
        repeat (3) @(negedge clk);
        applyStimulus(STATUS, 32'h0, 1'b0, 1'b0, rd);
        checkOutput("statusInAck", rd, 32'h40);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        checkOutput("txStartAfterRst", {31'h0, tx_start}, 32'h0);
        applyStimulus(STATUS, 32'h0, 1'b0, 1'b0, rd);
        checkOutput("statusAfterRst", rd, 32'h00);
        @(negedge clk); tx_busy = 1'b1;
        repeat (5) @(negedge clk);
        tx_busy = 1'b0;
        repeat (30) @(negedge clk);
        checkOutput("scoreboardEmpty", txQ.size(), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
